// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo block.
// Contents:
//   SYNC_FIFO_DATA_W_DEF  default entry width in bits
//   SYNC_FIFO_ADDR_W_DEF  default address width; depth is 2**ADDR_WIDTH
//   sync_fifo_depth()     depth from address width
package sync_fifo_pkg;

  localparam int SYNC_FIFO_DATA_W_DEF = 4;
  localparam int SYNC_FIFO_ADDR_W_DEF = 3;

  function automatic int sync_fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage for sync_fifo.
// It has one write port and one registered read port. The array itself is
// not reset. The read register is reset to zero.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (read register only)
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable; loads rdata_o from raddr_i
//   raddr_i  read address
//   rdata_o  registered read data; holds while re_i is low
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_FIFO_DATA_W_DEF,
  parameter int ADDR_WIDTH = SYNC_FIFO_ADDR_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = sync_fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read samples the old contents. So a same-edge write to the same slot
  // (full FIFO, read+write) does not alter the value returned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and registered read data.
// Full/empty flags are registered and derived from the next occupancy count.
// Optional feature macro SYNC_FIFO_ALMOST_FLAGS_EN adds the following:
//   the AF_LEVEL/AE_LEVEL parameters
//   the almost_full/almost_empty outputs
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   wen           write request
//   ren           read request
//   write_data    data stored on an accepted write
//   read_data     head entry, updated one edge after an accepted read
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   free slots <= AF_LEVEL (macro builds only)
//   almost_empty  count <= AE_LEVEL (macro builds only)
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_FIFO_DATA_W_DEF,
  parameter int ADDR_WIDTH = SYNC_FIFO_ADDR_W_DEF
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL = 1,
  parameter int AE_LEVEL = 1
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int DEPTH = sync_fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  rd_acc, wr_acc;

  // A full FIFO still takes a write when a read frees the head slot on the
  // same edge. An empty FIFO never reads, so there is no write-through.
  always_comb begin
    rd_acc   = ren && !empty_q;
    wr_acc   = wen && (!full_q || rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    if (wr_acc && !rd_acc) count_d = count_q + (ADDR_WIDTH+1)'(1);
    if (rd_acc && !wr_acc) count_d = count_q - (ADDR_WIDTH+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
    end
  end

  assign full  = full_q;
  assign empty = empty_q;

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic afull_q, aempty_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= ((DEPTH_C - count_d) <= AF_C);
      aempty_q <= (count_d <= AE_C);
    end
  end

  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
`endif

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (write_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (read_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo with default parameters.
// It runs directed scenarios and then random traffic. A queue model of the
// FIFO predicts every output.
module tb_sync_fifo;

  localparam int DW    = 4;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          wen;
  logic          ren;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .wen          (wen),
    .ren          (ren),
    .write_data   (write_data),
    .read_data    (read_data),
    .full         (full),
    .empty        (empty)
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Posedges fall at 0,10,20,...; so a release at 45 ns lands on a negedge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdata"}, 32'(read_data), 32'(exp_rd));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    check({tag, ".afull"},  32'(almost_full),  32'((DEPTH - model_q.size()) <= 1));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(model_q.size() <= 1));
`endif
  endtask

  // One clock of traffic. The model applies the FIFO rules at the edge, then
  // the outputs are compared 1 ns later.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wen = w; ren = r; write_data = d;
    @(posedge clk);
    rd_ok = r && (model_q.size() > 0);
    wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_rd = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    wen = 1'b0; ren = 1'b0; write_data = '0;
    exp_rd = '0;
    reset = 1'b1;
    #45;
    reset = 1'b0;
    #1;
    check_all("reset");
    check("reset.empty_c", 32'(empty), 32'd1);
    check("reset.rd_c", 32'(read_data), 32'd0);

    // Fill to full, then attempt one write that must be dropped.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(i), "fill");
    check("fill.full_c", 32'(full), 32'd1);
    step(1'b1, 1'b0, 4'd8, "wr_full");

    // Drain with one extra read; the data must come out in order 0..7.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 4'd0, "drain");
      check("drain.val", 32'(read_data), (i < 8) ? 32'(i) : 32'd7);
    end
    check("drain.empty_c", 32'(empty), 32'd1);

    // One entry, then a simultaneous read+write keeps one entry.
    step(1'b1, 1'b0, 4'd0, "one");
    step(1'b1, 1'b1, 4'd1, "rw1");
    check("rw1.val", 32'(read_data), 32'd0);
    check("rw1.empty_c", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 4'd0, "rd_last");
    check("rd_last.val", 32'(read_data), 32'd1);

    // Read+write on empty: only the write lands.
    step(1'b1, 1'b1, 4'hA, "rw_empty");
    check("rw_empty.val", 32'(read_data), 32'd1);
    step(1'b0, 1'b1, 4'd0, "rw_empty_rd");

    // Full plus simultaneous read+write.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(i + 3), "refill");
    step(1'b1, 1'b1, 4'hF, "rw_full");
    check("rw_full.val", 32'(read_data), 32'd3);

    // Async reset while holding entries: it takes effect without a clock edge.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd0, "trim");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    exp_rd = '0;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'd0, "post_rst_rd");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step(($urandom_range(99) < bias), ($urandom_range(99) < 100 - bias + 10),
           DW'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
